// File: rtl/riscalar_pkg.sv
// Shared types for the ALU reservation station: AluFunc codes, default
// widths and the station entry layout.
package riscalar_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int TAG_W_DEF = 4;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_func_e;

  // func is kept as a raw 4-bit code: codes 10-15 are carried through
  // untouched, so the field must not be restricted to the enum's members.
  typedef struct packed {
    logic                 valid;
    logic [3:0]           func;
    logic [TAG_W_DEF-1:0] dest_tag;
    logic                 src1_rdy;
    logic [TAG_W_DEF-1:0] src1_tag;
    logic [XLEN_DEF-1:0]  src1_val;
    logic                 src2_rdy;
    logic [TAG_W_DEF-1:0] src2_tag;
    logic [XLEN_DEF-1:0]  src2_val;
  } rs_entry_t;

endpackage

// File: rtl/alu_rs_oldest_ready_sel.sv
// Oldest-ready picker: among entries flagged ready, returns the one with
// the smallest age rank (rank 0 = oldest resident entry).
module rs_oldest_ready_sel #(
  parameter int DEPTH = 4,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]            ready_in,
  input  logic [DEPTH-1:0][IDX_W-1:0] age_in,
  output logic                        found_out,
  output logic [IDX_W-1:0]            idx_out
);

  logic [IDX_W-1:0] best_age;

  // linear scan keeping the minimum age among ready entries
  always_comb begin
    found_out = 1'b0;
    idx_out   = '0;
    best_age  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready_in[i] && (!found_out || age_in[i] < best_age)) begin
        found_out = 1'b1;
        idx_out   = IDX_W'(i);
        best_age  = age_in[i];
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station. Buffers dispatched ops, snoops the CDB for
// pending operands and issues the oldest ready op through a one-entry
// output register.
// Optional build macro ALU_RS_WAKEUP_BYPASS_EN: lets select treat a CDB
// broadcast as already-captured, cutting CDB-to-issue latency to 1 cycle.
// XLEN/TAG_W must stay at the riscalar_pkg defaults since rs_entry_t is
// sized from them.
module alu_rs
  import riscalar_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = XLEN_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       flush_in,
  input  logic                       disp_valid_in,
  output logic                       disp_ready_out,
  input  logic [3:0]                 disp_func_in,
  input  logic [TAG_W-1:0]           disp_dest_tag_in,
  input  logic                       disp_src1_rdy_in,
  input  logic [XLEN-1:0]            disp_src1_val_in,
  input  logic [TAG_W-1:0]           disp_src1_tag_in,
  input  logic                       disp_src2_rdy_in,
  input  logic [XLEN-1:0]            disp_src2_val_in,
  input  logic [TAG_W-1:0]           disp_src2_tag_in,
  input  logic                       cdb_valid_in,
  input  logic [TAG_W-1:0]           cdb_tag_in,
  input  logic [XLEN-1:0]            cdb_data_in,
  output logic                       issue_valid_out,
  input  logic                       issue_ready_in,
  output logic [3:0]                 issue_func_out,
  output logic [XLEN-1:0]            issue_rval1_out,
  output logic [XLEN-1:0]            issue_rval2_out,
  output logic [TAG_W-1:0]           issue_tag_out,
  output logic [$clog2(DEPTH+1)-1:0] count_out
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  rs_entry_t                 ent_q [DEPTH];
  rs_entry_t                 ent_d [DEPTH];
  // age rank: number of resident entries older than this one
  logic [DEPTH-1:0][IDX_W-1:0] age_q, age_d;
  logic [CNT_W-1:0]          count_q, count_d;

  logic                      out_valid_q, out_valid_d;
  logic [3:0]                out_func_q, out_func_d;
  logic [XLEN-1:0]           out_rv1_q, out_rv1_d;
  logic [XLEN-1:0]           out_rv2_q, out_rv2_d;
  logic [TAG_W-1:0]          out_tag_q, out_tag_d;

  logic                      disp_acc;
  logic [IDX_W-1:0]          free_idx;
  logic [DEPTH-1:0]          s1_hit, s2_hit, sel_ready;
  logic                      sel_found, load;
  logic [IDX_W-1:0]          sel_idx;
  rs_entry_t                 sel_ent, new_ent;
  logic [XLEN-1:0]           sel_rv1, sel_rv2;

  assign disp_ready_out = (count_q < CNT_W'(DEPTH));
  assign disp_acc       = disp_valid_in && disp_ready_out;

  // lowest invalid slot receives the next dispatch
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!ent_q[i].valid) free_idx = IDX_W'(i);
    end
  end

  // per-entry CDB match on pending sources, and selectability
  always_comb begin
    s1_hit    = '0;
    s2_hit    = '0;
    sel_ready = '0;
    for (int i = 0; i < DEPTH; i++) begin
      s1_hit[i] = cdb_valid_in && !ent_q[i].src1_rdy && (ent_q[i].src1_tag == cdb_tag_in);
      s2_hit[i] = cdb_valid_in && !ent_q[i].src2_rdy && (ent_q[i].src2_tag == cdb_tag_in);
`ifdef ALU_RS_WAKEUP_BYPASS_EN
      sel_ready[i] = ent_q[i].valid && (ent_q[i].src1_rdy || s1_hit[i])
                                    && (ent_q[i].src2_rdy || s2_hit[i]);
`else
      sel_ready[i] = ent_q[i].valid && ent_q[i].src1_rdy && ent_q[i].src2_rdy;
`endif
    end
  end

  rs_oldest_ready_sel #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_sel (
    .ready_in  (sel_ready),
    .age_in    (age_q),
    .found_out (sel_found),
    .idx_out   (sel_idx)
  );

  assign sel_ent = ent_q[sel_idx];
  assign load    = sel_found && (!out_valid_q || issue_ready_in);

  // operand values handed to the output register (CDB forwarded if bypassing)
  always_comb begin
    sel_rv1 = sel_ent.src1_val;
    sel_rv2 = sel_ent.src2_val;
`ifdef ALU_RS_WAKEUP_BYPASS_EN
    if (!sel_ent.src1_rdy) sel_rv1 = cdb_data_in;
    if (!sel_ent.src2_rdy) sel_rv2 = cdb_data_in;
`endif
  end

  // incoming entry, including a capture of a same-cycle CDB broadcast
  always_comb begin
    new_ent          = '0;
    new_ent.valid    = 1'b1;
    new_ent.func     = disp_func_in;
    new_ent.dest_tag = disp_dest_tag_in;
    new_ent.src1_rdy = disp_src1_rdy_in;
    new_ent.src1_tag = disp_src1_tag_in;
    new_ent.src1_val = disp_src1_val_in;
    new_ent.src2_rdy = disp_src2_rdy_in;
    new_ent.src2_tag = disp_src2_tag_in;
    new_ent.src2_val = disp_src2_val_in;
    if (!disp_src1_rdy_in && cdb_valid_in && (disp_src1_tag_in == cdb_tag_in)) begin
      new_ent.src1_rdy = 1'b1;
      new_ent.src1_val = cdb_data_in;
    end
    if (!disp_src2_rdy_in && cdb_valid_in && (disp_src2_tag_in == cdb_tag_in)) begin
      new_ent.src2_rdy = 1'b1;
      new_ent.src2_val = cdb_data_in;
    end
  end

  // next state: wakeup, move to output register, dispatch, flush
  always_comb begin
    ent_d       = ent_q;
    age_d       = age_q;
    count_d     = count_q + CNT_W'(disp_acc) - CNT_W'(load);
    out_valid_d = out_valid_q;
    out_func_d  = out_func_q;
    out_rv1_d   = out_rv1_q;
    out_rv2_d   = out_rv2_q;
    out_tag_d   = out_tag_q;

    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[i].valid) begin
        if (s1_hit[i]) begin
          ent_d[i].src1_rdy = 1'b1;
          ent_d[i].src1_val = cdb_data_in;
        end
        if (s2_hit[i]) begin
          ent_d[i].src2_rdy = 1'b1;
          ent_d[i].src2_val = cdb_data_in;
        end
      end
    end

    if (load) begin
      ent_d[sel_idx].valid = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_q[i].valid && (age_q[i] > age_q[sel_idx])) age_d[i] = age_q[i] - IDX_W'(1);
      end
      out_valid_d = 1'b1;
      out_func_d  = sel_ent.func;
      out_rv1_d   = sel_rv1;
      out_rv2_d   = sel_rv2;
      out_tag_d   = sel_ent.dest_tag;
    end else if (issue_ready_in) begin
      out_valid_d = 1'b0;
    end

    if (disp_acc) begin
      ent_d[free_idx] = new_ent;
      age_d[free_idx] = IDX_W'(count_q - CNT_W'(load));
    end

    if (flush_in) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i].valid = 1'b0;
      count_d     = '0;
      out_valid_d = 1'b0;
      out_func_d  = '0;
      out_rv1_d   = '0;
      out_rv2_d   = '0;
      out_tag_d   = '0;
    end
  end

  // state registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      age_q       <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_func_q  <= '0;
      out_rv1_q   <= '0;
      out_rv2_q   <= '0;
      out_tag_q   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      age_q       <= age_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_func_q  <= out_func_d;
      out_rv1_q   <= out_rv1_d;
      out_rv2_q   <= out_rv2_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign issue_valid_out = out_valid_q;
  assign issue_func_out  = out_func_q;
  assign issue_rval1_out = out_rv1_q;
  assign issue_rval2_out = out_rv2_q;
  assign issue_tag_out   = out_tag_q;
  assign count_out       = count_q;

endmodule

// File: tb/tb_alu_rs.sv
// Bench for alu_rs: directed scenarios plus random traffic, all checked
// against an in-order queue model of the station.
module tb_alu_rs;
  import riscalar_pkg::*;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int TAG_W = 4;

  logic             clk_in = 1'b0;
  logic             rst_n_in = 1'b0;
  logic             flush_in = 1'b0;
  logic             disp_valid_in = 1'b0;
  logic             disp_ready_out;
  logic [3:0]       disp_func_in = '0;
  logic [TAG_W-1:0] disp_dest_tag_in = '0;
  logic             disp_src1_rdy_in = 1'b0;
  logic [XLEN-1:0]  disp_src1_val_in = '0;
  logic [TAG_W-1:0] disp_src1_tag_in = '0;
  logic             disp_src2_rdy_in = 1'b0;
  logic [XLEN-1:0]  disp_src2_val_in = '0;
  logic [TAG_W-1:0] disp_src2_tag_in = '0;
  logic             cdb_valid_in = 1'b0;
  logic [TAG_W-1:0] cdb_tag_in = '0;
  logic [XLEN-1:0]  cdb_data_in = '0;
  logic             issue_valid_out;
  logic             issue_ready_in = 1'b1;
  logic [3:0]       issue_func_out;
  logic [XLEN-1:0]  issue_rval1_out;
  logic [XLEN-1:0]  issue_rval2_out;
  logic [TAG_W-1:0] issue_tag_out;
  logic [2:0]       count_out;

  alu_rs #(.DEPTH(DEPTH), .XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .flush_in(flush_in),
    .disp_valid_in(disp_valid_in), .disp_ready_out(disp_ready_out),
    .disp_func_in(disp_func_in), .disp_dest_tag_in(disp_dest_tag_in),
    .disp_src1_rdy_in(disp_src1_rdy_in), .disp_src1_val_in(disp_src1_val_in),
    .disp_src1_tag_in(disp_src1_tag_in), .disp_src2_rdy_in(disp_src2_rdy_in),
    .disp_src2_val_in(disp_src2_val_in), .disp_src2_tag_in(disp_src2_tag_in),
    .cdb_valid_in(cdb_valid_in), .cdb_tag_in(cdb_tag_in), .cdb_data_in(cdb_data_in),
    .issue_valid_out(issue_valid_out), .issue_ready_in(issue_ready_in),
    .issue_func_out(issue_func_out), .issue_rval1_out(issue_rval1_out),
    .issue_rval2_out(issue_rval2_out), .issue_tag_out(issue_tag_out),
    .count_out(count_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [3:0]  func;
    logic [3:0]  dtag;
    bit          r1;
    logic [31:0] v1;
    logic [3:0]  t1;
    bit          r2;
    logic [31:0] v2;
    logic [3:0]  t2;
  } m_ent_t;

  m_ent_t      m_q[$];
  bit          mo_v;
  logic [3:0]  mo_f;
  logic [31:0] mo_r1, mo_r2;
  logic [3:0]  mo_t;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_ready(m_ent_t e);
`ifdef ALU_RS_WAKEUP_BYPASS_EN
    return (e.r1 || (cdb_valid_in && e.t1 == cdb_tag_in)) &&
           (e.r2 || (cdb_valid_in && e.t2 == cdb_tag_in));
`else
    return e.r1 && e.r2;
`endif
  endfunction

  task automatic m_clear();
    m_q.delete();
    mo_v = 0; mo_f = 0; mo_r1 = 0; mo_r2 = 0; mo_t = 0;
  endtask

  task automatic clr_in();
    disp_valid_in = 0; cdb_valid_in = 0; flush_in = 0;
  endtask

  task automatic disp(input logic [3:0] f, input logic [3:0] dt,
                      input bit r1, input logic [31:0] v1, input logic [3:0] t1,
                      input bit r2, input logic [31:0] v2, input logic [3:0] t2);
    disp_valid_in = 1; disp_func_in = f; disp_dest_tag_in = dt;
    disp_src1_rdy_in = r1; disp_src1_val_in = v1; disp_src1_tag_in = t1;
    disp_src2_rdy_in = r2; disp_src2_val_in = v2; disp_src2_tag_in = t2;
  endtask

  task automatic cdb(input logic [3:0] t, input logic [31:0] d);
    cdb_valid_in = 1; cdb_tag_in = t; cdb_data_in = d;
  endtask

  // one clock: compare against the model at negedge, advance the model, pass the edge
  task automatic cycle();
    m_ent_t e;
    int     sel;
    bit     acc, load;
    @(negedge clk_in);
    chk("disp_ready", 32'(disp_ready_out), 32'(m_q.size() < DEPTH));
    chk("count", 32'(count_out), 32'(m_q.size()));
    chk("issue_valid", 32'(issue_valid_out), 32'(mo_v));
    if (mo_v) begin
      chk("issue_func", 32'(issue_func_out), 32'(mo_f));
      chk("issue_rval1", issue_rval1_out, mo_r1);
      chk("issue_rval2", issue_rval2_out, mo_r2);
      chk("issue_tag", 32'(issue_tag_out), 32'(mo_t));
    end
    if (flush_in) begin
      m_q.delete();
      mo_v = 0;
    end else begin
      acc = disp_valid_in && (m_q.size() < DEPTH);
      sel = -1;
      for (int k = 0; k < m_q.size(); k++)
        if (sel < 0 && m_ready(m_q[k])) sel = k;
      load = (sel >= 0) && (!mo_v || issue_ready_in);
      if (load) begin
        mo_v  = 1;
        mo_f  = m_q[sel].func;
        mo_t  = m_q[sel].dtag;
        mo_r1 = m_q[sel].r1 ? m_q[sel].v1 : cdb_data_in;
        mo_r2 = m_q[sel].r2 ? m_q[sel].v2 : cdb_data_in;
        m_q.delete(sel);
      end else if (issue_ready_in) begin
        mo_v = 0;
      end
      if (cdb_valid_in) begin
        for (int k = 0; k < m_q.size(); k++) begin
          if (!m_q[k].r1 && m_q[k].t1 == cdb_tag_in) begin m_q[k].r1 = 1; m_q[k].v1 = cdb_data_in; end
          if (!m_q[k].r2 && m_q[k].t2 == cdb_tag_in) begin m_q[k].r2 = 1; m_q[k].v2 = cdb_data_in; end
        end
      end
      if (acc) begin
        e.func = disp_func_in; e.dtag = disp_dest_tag_in;
        e.r1 = disp_src1_rdy_in; e.v1 = disp_src1_val_in; e.t1 = disp_src1_tag_in;
        e.r2 = disp_src2_rdy_in; e.v2 = disp_src2_val_in; e.t2 = disp_src2_tag_in;
        if (!e.r1 && cdb_valid_in && e.t1 == cdb_tag_in) begin e.r1 = 1; e.v1 = cdb_data_in; end
        if (!e.r2 && cdb_valid_in && e.t2 == cdb_tag_in) begin e.r2 = 1; e.v2 = cdb_data_in; end
        m_q.push_back(e);
      end
    end
    @(posedge clk_in); #1;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid"}, 32'(issue_valid_out), 0);
    chk({tag, "_func"}, 32'(issue_func_out), 0);
    chk({tag, "_rval1"}, issue_rval1_out, 0);
    chk({tag, "_rval2"}, issue_rval2_out, 0);
    chk({tag, "_tag"}, 32'(issue_tag_out), 0);
    chk({tag, "_count"}, 32'(count_out), 0);
  endtask

  initial begin
    m_clear();
    #2;
    chk_zero_outputs("reset");
    @(posedge clk_in); @(posedge clk_in); #1;
    rst_n_in = 1;
    #1;
    chk("rst_ready", 32'(disp_ready_out), 1);

    // plain ready op: 2-cycle latency
    issue_ready_in = 1;
    disp(ALU_ADD, 3, 1, 12, 0, 1, 10, 0);
    cycle(); clr_in();
    cycle();
    chk("t1_valid", 32'(issue_valid_out), 1);
    chk("t1_func", 32'(issue_func_out), 0);
    chk("t1_rval1", issue_rval1_out, 12);
    chk("t1_rval2", issue_rval2_out, 10);
    chk("t1_tag", 32'(issue_tag_out), 3);
    chk("t1_count", 32'(count_out), 0);
    cycle();

    // pending src1 woken by CDB
    disp(ALU_SUB, 4, 0, 0, 5, 1, 10, 0);
    cycle(); clr_in();
    cycle(); cycle();
    cdb(5, 12);
    cycle(); clr_in();
`ifdef ALU_RS_WAKEUP_BYPASS_EN
    chk("t2_valid", 32'(issue_valid_out), 1);
`else
    chk("t2_early", 32'(issue_valid_out), 0);
    cycle();
    chk("t2_valid", 32'(issue_valid_out), 1);
`endif
    chk("t2_rval1", issue_rval1_out, 12);
    chk("t2_rval2", issue_rval2_out, 10);
    cycle(); cycle();

    // fill with ops pending on tag 7, reject a 5th, then release all at once
    for (int k = 0; k < 4; k++) begin
      disp(4'(10 + k), 4'(8 + k), 0, 0, 7, 1, 32'(k), 0);
      cycle();
    end
    disp(ALU_XOR, 15, 1, 1, 0, 1, 1, 0);
    chk("t3_ready", 32'(disp_ready_out), 0);
    chk("t3_count", 32'(count_out), 4);
    cycle(); clr_in();
    cycle();
    cdb(7, 1);
    cycle(); clr_in();
    for (int k = 0; k < 6; k++) cycle();

    // stalled ALU: And held, then And, Or, Sra in order
    issue_ready_in = 0;
    disp(ALU_AND, 1, 1, 5, 0, 1, 3, 0); cycle();
    disp(ALU_OR,  2, 1, 6, 0, 1, 4, 0); cycle();
    disp(ALU_SRA, 3, 1, 7, 0, 1, 2, 0); cycle();
    clr_in();
    for (int k = 0; k < 5; k++) cycle();
    chk("t4_hold_func", 32'(issue_func_out), 32'(ALU_AND));
    issue_ready_in = 1;
    for (int k = 0; k < 4; k++) cycle();

    // capture of a CDB broadcast in the dispatch cycle
    disp(ALU_ADD, 12, 1, 7, 0, 0, 0, 9);
    cdb(9, 32'hFFFF_FFF0);
    cycle(); clr_in();
    cycle();
    chk("t5_valid", 32'(issue_valid_out), 1);
    chk("t5_rval2", issue_rval2_out, 32'hFFFF_FFF0);
    cycle();

    // flush with 3 entries and a held output, overriding dispatch/wakeup
    issue_ready_in = 0;
    for (int k = 0; k < 4; k++) begin
      disp(ALU_OR, 4'(k), 1, 32'(k), 0, 0, 0, 2);
      cycle();
    end
    cdb(2, 32'h55); cycle(); clr_in();
    cycle();
    chk("t6_count", 32'(count_out), 3);
    chk("t6_held", 32'(issue_valid_out), 1);
    flush_in = 1;
    disp(ALU_ADD, 9, 1, 1, 0, 1, 1, 0);
    cdb(2, 32'h66);
    cycle(); clr_in();
    chk("t6_flush_valid", 32'(issue_valid_out), 0);
    chk("t6_flush_count", 32'(count_out), 0);

    // asynchronous reset in the middle of a cycle
    disp(ALU_ADD, 5, 1, 2, 0, 1, 3, 0); cycle();
    disp(ALU_SUB, 6, 1, 4, 0, 1, 5, 0); cycle();
    clr_in(); cycle();
    #2;
    rst_n_in = 0;
    #1;
    chk_zero_outputs("midrst");
    m_clear();
    @(posedge clk_in); #1;
    rst_n_in = 1;
    issue_ready_in = 1;
    cycle();

    // random traffic
    for (int n = 0; n < 800; n++) begin
      issue_ready_in = ($urandom_range(0, 9) < 7);
      flush_in       = ($urandom_range(0, 59) == 0);
      disp_valid_in  = ($urandom_range(0, 9) < 6);
      disp_func_in   = 4'($urandom_range(0, 15));
      disp_dest_tag_in = 4'($urandom_range(0, 15));
      disp_src1_rdy_in = $urandom_range(0, 1) == 1;
      disp_src1_val_in = $urandom;
      disp_src1_tag_in = 4'($urandom_range(0, 7));
      disp_src2_rdy_in = $urandom_range(0, 1) == 1;
      disp_src2_val_in = $urandom;
      disp_src2_tag_in = 4'($urandom_range(0, 7));
      cdb_valid_in   = $urandom_range(0, 1) == 1;
      cdb_tag_in     = 4'($urandom_range(0, 7));
      cdb_data_in    = $urandom;
      cycle();
    end
    clr_in();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_rs.md
Name: alu_rs

Overview:
- Reservation station directly upstream of the ALU.
- Buffers dispatched ALU ops whose source operands may still be pending.
- Snoops the common data bus (CDB) for results and captures operand values as they arrive.
- Issues the oldest fully-ready op to the ALU over a valid/ready handshake, presenting func, rval1, rval2 and destination tag.

Parameters:
- DEPTH, 4, number of station entries (power of 2, ≥2)
- XLEN, 32, operand width
- TAG_W, 4, ROB/physical tag width

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  reset; asynchronous, active-low (fixed; clock/reset named per codebase convention)
- flush_in  input  1  synchronous squash of all contents
- disp_valid_in  input  1  dispatch request
- disp_ready_out  output  1  station can accept dispatch
- disp_func_in  input  4  AluFunc code
- disp_dest_tag_in  input  TAG_W  result tag
- disp_src1_rdy_in  input  1  src1 value valid
- disp_src1_val_in  input  XLEN  src1 value
- disp_src1_tag_in  input  TAG_W  src1 producer tag
- disp_src2_rdy_in, disp_src2_val_in, disp_src2_tag_in  input  1/XLEN/TAG_W  same for src2
- cdb_valid_in  input  1  CDB broadcast valid
- cdb_tag_in  input  TAG_W  broadcast tag
- cdb_data_in  input  XLEN  broadcast value
- issue_valid_out  output  1  op presented to ALU
- issue_ready_in  input  1  ALU accepts
- issue_func_out  output  4  AluFunc to ALU
- issue_rval1_out  output  XLEN  operand 1
- issue_rval2_out  output  XLEN  operand 2
- issue_tag_out  output  TAG_W  destination tag
- count_out  output  $clog2(DEPTH+1)  occupied entries, output register excluded

Behaviour:
- Reset (async, rst_n_in low):
  - All entries invalid.
  - issue_valid_out, issue_func_out, issue_rval1_out, issue_rval2_out, issue_tag_out = 0.
  - count_out = 0.
  - disp_ready_out = 1 once reset is released.
  - Reset mid-operation drops all contents immediately; no partial issue.
- Dispatch:
  - disp_ready_out = (count_out < DEPTH), from registered state only.
  - Dispatch is accepted when disp_valid_in && disp_ready_out; the op is written to the lowest free index at the clock edge.
  - At full, a same-cycle issue does not open a slot; disp_ready_out stays 0.
- Dispatch-time capture:
  - If a src is not ready and cdb_valid_in && cdb_tag_in matches its tag in the dispatch cycle, the entry stores cdb_data_in and marks that src ready.
  - This is mandatory, to avoid lost wakeups.
- Wakeup: each cycle with cdb_valid_in, every valid entry with a pending src whose tag equals cdb_tag_in captures cdb_data_in. Both srcs may wake on the same broadcast.
- Select:
  - Picks the oldest (dispatch order) valid entry with both srcs ready.
  - Age is tracked independently of index; it must survive out-of-order removal.
- Output register:
  - One-entry register drives the issue_* outputs.
  - It loads the selected entry (and frees it) when empty or when issue_valid_out && issue_ready_in in that cycle. Back-to-back issue runs at 1 op/cycle.
  - While issue_valid_out && !issue_ready_in, all issue_* outputs hold stable.
- Latency: dispatch with both srcs ready → issue_valid_out 2 cycles later (write edge, then select/load edge). CDB wakeup → issue_valid_out 2 cycles after the broadcast cycle.
- Func codes:
  - AluFunc (Add=0, Sub=1, And=2, Or=3, Xor=4, Slt=5, Sltu=6, Sll=7, Srl=8, Sra=9) passes through unmodified.
  - Codes 10–15 are stored and issued as-is; the station does not decode them.
- flush_in:
  - Clears all entries and the output register at the next edge.
  - Overrides a same-cycle dispatch, wakeup and issue; issue_valid_out = 0 the cycle after.
- count_out: +1 on accepted dispatch, −1 on an entry moving to the output register; both in one cycle leave it unchanged.

Optional Feature:
- Macro: ALU_RS_WAKEUP_BYPASS_EN.
- When defined, select also treats an entry as ready if its last pending src matches the current CDB broadcast, using cdb_data_in for that operand when loading the output register. CDB-to-issue latency drops to 1 cycle.
- When undefined, only registered-ready entries are selectable (2 cycles).

Decomposition:
- riscalar_pkg holds:
  - the AluFunc enum (4-bit, values above)
  - XLEN and TAG_W defaults
  - the rs_entry_t struct (valid, func, dest_tag, per-src rdy/tag/val)
- One sub-module: rs_oldest_ready_sel. Inputs are per-entry ready and age; outputs are a found flag and the winning index.

Test Plan:
- Dispatch Add, src1=12, src2=10 (both ready), tag 3, issue_ready_in=1 → two cycles later issue_valid_out=1, func=0, rval1=12, rval2=10, tag=3; count_out returns to 0.
- Dispatch Sub with src1 pending on tag 5 and src2=10; three cycles later CDB tag 5 data 12 → issue rval1=12, rval2=10 two cycles after the broadcast (one cycle with ALU_RS_WAKEUP_BYPASS_EN).
- Dispatch 4 ops all pending on tag 7 → disp_ready_out=0, count_out=4, a 5th dispatch is ignored; then CDB tag 7 data 1 → all four issue in dispatch order on consecutive cycles.
- Three ready ops (And, Or, Sra) with issue_ready_in=0 for 5 cycles → And is held stable on the outputs; on release the ops issue in order And, Or, Sra.
- Dispatch with src2 tag 9 while the same cycle carries CDB tag 9 data 0xFFFF_FFF0 → entry captures 0xFFFF_FFF0 and issues with no deadlock.
- With 3 entries plus a held output, assert flush_in → issue_valid_out=0 and count_out=0 next cycle; separately, pull rst_n_in low mid-cycle → outputs go to 0 immediately.
